hamming_secded_rx_ctrl: RTL and testbench

//  Receive-side controller for the SECDED(8,4) decode datapath.
//  - Accepts codewords on a valid/ready stream and computes syndrome and overall parity.
//  - Drives a hamming_secded_corrector instance and classifies each word.
//  - Emits the decoded nibble with status on an output stream and keeps saturating error counters.
//  - Optionally halts intake on an uncorrectable (double) error until software clears it.

---
 rtl/hamming_secded_rx_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_hamming_secded_rx_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/hamming_secded_rx_ctrl.sv
// SECDED(8,4) receive controller: two-stage valid/ready pipeline around a
// single-error corrector, with saturating statistics and optional halt on DED.

module hamming_secded_corrector (
    input  logic [7:0] cw,
    input  logic [2:0] syn,
    input  logic       ov,
    output logic [7:0] cw_fix,
    output logic [3:0] data
);
    // Position 1 lives in cw[2], position 2 in cw[1]; syn=0 with ov=1 is the p0 bit.
    always_comb begin
        cw_fix = cw;
        if (ov) begin
            case (syn)
                3'd0:    cw_fix[0]   = ~cw[0];
                3'd1:    cw_fix[2]   = ~cw[2];
                3'd2:    cw_fix[1]   = ~cw[1];
                default: cw_fix[syn] = ~cw[syn];
            endcase
        end
        data = {cw_fix[7], cw_fix[6], cw_fix[5], cw_fix[3]};
    end
endmodule

module hamming_secded_rx_ctrl #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned HALT_ON_DED = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_cw,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data,
    output logic [7:0]       out_cw,
    output logic [2:0]       out_syn,
    output logic [1:0]       out_status,
    input  logic             clr,
    output logic             halted,
    output logic             sticky_ded,
    output logic [CNT_W-1:0] cnt_ok,
    output logic [CNT_W-1:0] cnt_cor,
    output logic [CNT_W-1:0] cnt_ded
);
    typedef enum logic {RUN, HALT} state_t;
    typedef enum logic [1:0] {ST_CLEAN = 2'b00, ST_COR = 2'b01, ST_DED = 2'b10} status_t;

    state_t          state_q, state_d;
    logic            s1_valid_q, s1_valid_d;
    logic [7:0]      s1_cw_q, s1_cw_d;
    logic            out_valid_q, out_valid_d;
    logic [3:0]      out_data_q, out_data_d;
    logic [7:0]      out_cw_q, out_cw_d;
    logic [2:0]      out_syn_q, out_syn_d;
    status_t         out_status_q, out_status_d;
    logic            sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_ok_q, cnt_ok_d, cnt_cor_q, cnt_cor_d, cnt_ded_q, cnt_ded_d;

    logic       run, s2_load, in_fire, out_fire, ov;
    logic [2:0] syn;
    logic [7:0] cw_fix;
    logic [3:0] data_fix;
    status_t    status;

    assign syn[0] = s1_cw_q[2] ^ s1_cw_q[3] ^ s1_cw_q[5] ^ s1_cw_q[7];
    assign syn[1] = s1_cw_q[1] ^ s1_cw_q[3] ^ s1_cw_q[6] ^ s1_cw_q[7];
    assign syn[2] = s1_cw_q[4] ^ s1_cw_q[5] ^ s1_cw_q[6] ^ s1_cw_q[7];
    assign ov     = ^s1_cw_q;

    hamming_secded_corrector u_corr (
        .cw     (s1_cw_q),
        .syn    (syn),
        .ov     (ov),
        .cw_fix (cw_fix),
        .data   (data_fix)
    );

    always_comb begin
        if (ov)             status = ST_COR;
        else if (syn != '0) status = ST_DED;
        else                status = ST_CLEAN;
    end

    always_comb begin
        run      = (state_q == RUN);
        halted   = (state_q == HALT);
        s2_load  = s1_valid_q & (~out_valid_q | out_ready) & run;
        in_ready = run & (~s1_valid_q | s2_load);
        in_fire  = in_valid & in_ready;
        out_fire = out_valid_q & out_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:  if ((HALT_ON_DED != 0) && s2_load && status == ST_DED) state_d = HALT;
            HALT: if (clr) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_cw_d      = s1_cw_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_cw_d     = out_cw_q;
        out_syn_d    = out_syn_q;
        out_status_d = out_status_q;
        sticky_d     = sticky_q;
        cnt_ok_d     = cnt_ok_q;
        cnt_cor_d    = cnt_cor_q;
        cnt_ded_d    = cnt_ded_q;

        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_cw_d    = in_cw;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        if (s2_load) begin
            out_valid_d  = 1'b1;
            out_data_d   = data_fix;
            out_cw_d     = (status == ST_DED) ? s1_cw_q : cw_fix;
            out_syn_d    = syn;
            out_status_d = status;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end

        // clr outranks a coincident handshake, so it is applied last.
        if (out_fire) begin
            case (out_status_q)
                ST_CLEAN: if (cnt_ok_q  != '1) cnt_ok_d  = cnt_ok_q  + 1'b1;
                ST_COR:   if (cnt_cor_q != '1) cnt_cor_d = cnt_cor_q + 1'b1;
                ST_DED: begin
                    if (cnt_ded_q != '1) cnt_ded_d = cnt_ded_q + 1'b1;
                    sticky_d = 1'b1;
                end
                default: ;
            endcase
        end
        if (clr) begin
            cnt_ok_d  = '0;
            cnt_cor_d = '0;
            cnt_ded_d = '0;
            sticky_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_cw_q      <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_cw_q     <= '0;
            out_syn_q    <= '0;
            out_status_q <= ST_CLEAN;
            sticky_q     <= 1'b0;
            cnt_ok_q     <= '0;
            cnt_cor_q    <= '0;
            cnt_ded_q    <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_cw_q      <= s1_cw_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_cw_q     <= out_cw_d;
            out_syn_q    <= out_syn_d;
            out_status_q <= out_status_d;
            sticky_q     <= sticky_d;
            cnt_ok_q     <= cnt_ok_d;
            cnt_cor_q    <= cnt_cor_d;
            cnt_ded_q    <= cnt_ded_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_cw     = out_cw_q;
    assign out_syn    = out_syn_q;
    assign out_status = out_status_q;
    assign sticky_ded = sticky_q;
    assign cnt_ok     = cnt_ok_q;
    assign cnt_cor    = cnt_cor_q;
    assign cnt_ded    = cnt_ded_q;
endmodule

// File: tb/tb_hamming_secded_rx_ctrl.sv
// Bench for hamming_secded_rx_ctrl: directed codewords, a transmit queue feeding
// the input stream and a scoreboard queue checked against the output stream.

module tb_hamming_secded_rx_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, clr, halted, sticky_ded;
    logic [7:0]  in_cw, out_cw;
    logic [3:0]  out_data;
    logic [2:0]  out_syn;
    logic [1:0]  out_status;
    logic [15:0] cnt_ok, cnt_cor, cnt_ded;

    logic       b_in_valid, b_in_ready, b_out_valid, b_clr, b_halted, b_sticky;
    logic [7:0] b_in_cw, b_out_cw;
    logic [3:0] b_out_data;
    logic [2:0] b_out_syn;
    logic [1:0] b_out_status, b_cnt_ok, b_cnt_cor, b_cnt_ded;

    int unsigned vectors = 0, miscompares = 0, ncyc = 0, acc = 0, b_acc = 0;
    bit lat_chk = 0, stall_prev = 0, found;
    logic [17:0] stall_snap;

    typedef struct {
        logic [7:0]  cw;
        logic [3:0]  d;
        logic [7:0]  fcw;
        logic [2:0]  syn;
        logic [1:0]  st;
        int unsigned t;
    } vec_t;
    vec_t tx[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    hamming_secded_rx_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_cw(in_cw),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_cw(out_cw),
        .out_syn(out_syn), .out_status(out_status), .clr(clr), .halted(halted),
        .sticky_ded(sticky_ded), .cnt_ok(cnt_ok), .cnt_cor(cnt_cor), .cnt_ded(cnt_ded)
    );

    hamming_secded_rx_ctrl #(.CNT_W(2), .HALT_ON_DED(1)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_cw(b_in_cw),
        .out_valid(b_out_valid), .out_ready(1'b1), .out_data(b_out_data), .out_cw(b_out_cw),
        .out_syn(b_out_syn), .out_status(b_out_status), .clr(b_clr), .halted(b_halted),
        .sticky_ded(b_sticky), .cnt_ok(b_cnt_ok), .cnt_cor(b_cnt_cor), .cnt_ded(b_cnt_ded)
    );

    function automatic vec_t mk(logic [7:0] cw, logic [3:0] d, logic [7:0] fcw,
                                logic [2:0] syn, logic [1:0] st);
        vec_t v;
        v.cw = cw; v.d = d; v.fcw = fcw; v.syn = syn; v.st = st; v.t = 0;
        return v;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: drive inputs, observe both streams at negedge, advance past posedge.
    task automatic cyc();
        vec_t e;
        in_valid = (tx.size() != 0);
        in_cw    = (tx.size() != 0) ? tx[0].cw : 8'h00;
        @(negedge clk);
        if (out_ready && sb.size() == 0) begin
            chk("no_stale_word", {31'd0, out_valid}, 32'd0);
        end else if (out_valid && out_ready) begin
            e = sb.pop_front();
            chk("out_data", {28'd0, out_data}, {28'd0, e.d});
            chk("out_cw", {24'd0, out_cw}, {24'd0, e.fcw});
            chk("out_syn", {29'd0, out_syn}, {29'd0, e.syn});
            chk("out_status", {30'd0, out_status}, {30'd0, e.st});
            if (lat_chk) chk("latency", ncyc - e.t, 32'd2);
        end
        if (stall_prev)
            chk("stall_stable", {14'd0, out_valid, out_data, out_cw, out_syn, out_status},
                {14'd0, stall_snap});
        stall_prev = out_valid && !out_ready;
        stall_snap = {out_valid, out_data, out_cw, out_syn, out_status};
        if (in_valid && in_ready) begin
            e = tx.pop_front();
            e.t = ncyc;
            sb.push_back(e);
            acc++;
        end
        if (b_in_valid && b_in_ready) b_acc++;
        ncyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(string tag);
        for (int i = 0; i < 40 && (tx.size() != 0 || sb.size() != 0); i++) cyc();
        chk(tag, tx.size() + sb.size(), 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_cw = 8'h00; out_ready = 1'b1; clr = 1'b0;
        b_in_valid = 1'b0; b_in_cw = 8'h00; b_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_sticky", {31'd0, sticky_ded}, 32'd0);
        chk("rst_cnt_ok", {16'd0, cnt_ok}, 32'd0);
        chk("rst_out_word", {18'd0, out_data, out_cw, out_syn, out_status}, 32'd0);
        rst = 1'b0;
        cyc();

        // Clean stream, back to back, with latency tracking.
        lat_chk = 1'b1;
        tx.push_back(mk(8'h00, 4'h0, 8'h00, 3'd0, 2'd0));
        tx.push_back(mk(8'hFF, 4'hF, 8'hFF, 3'd0, 2'd0));
        tx.push_back(mk(8'h69, 4'h7, 8'h69, 3'd0, 2'd0));
        drain("drain_clean");
        lat_chk = 1'b0;
        chk("cnt_ok_clean", {16'd0, cnt_ok}, 32'd3);

        // Single data-bit error and p0 error.
        tx.push_back(mk(8'h49, 4'h7, 8'h69, 3'd5, 2'd1));
        tx.push_back(mk(8'h68, 4'h7, 8'h69, 3'd0, 2'd1));
        drain("drain_cor");
        chk("cnt_cor_two", {16'd0, cnt_cor}, 32'd2);
        chk("cnt_ok_keep", {16'd0, cnt_ok}, 32'd3);

        // Double error halts intake; the word behind it waits in S1.
        tx.push_back(mk(8'h41, 4'h4, 8'h41, 3'd6, 2'd2));
        tx.push_back(mk(8'h00, 4'h0, 8'h00, 3'd0, 2'd0));
        tx.push_back(mk(8'hFF, 4'hF, 8'hFF, 3'd0, 2'd0));
        repeat (6) cyc();
        chk("halted_set", {31'd0, halted}, 32'd1);
        chk("halt_in_ready", {31'd0, in_ready}, 32'd0);
        chk("sticky_set", {31'd0, sticky_ded}, 32'd1);
        chk("cnt_ded_one", {16'd0, cnt_ded}, 32'd1);
        chk("halt_tx_held", tx.size(), 32'd1);
        chk("halt_s1_held", sb.size(), 32'd1);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        chk("clr_halted", {31'd0, halted}, 32'd0);
        chk("clr_in_ready", {31'd0, in_ready}, 32'd1);
        chk("clr_sticky", {31'd0, sticky_ded}, 32'd0);
        chk("clr_cnt_ded", {16'd0, cnt_ded}, 32'd0);
        chk("clr_cnt_cor", {16'd0, cnt_cor}, 32'd0);
        drain("drain_halt");
        chk("cnt_ok_after_clr", {16'd0, cnt_ok}, 32'd2);

        // Downstream stall with four words offered.
        out_ready = 1'b0;
        acc = 0;
        tx.push_back(mk(8'h00, 4'h0, 8'h00, 3'd0, 2'd0));
        tx.push_back(mk(8'hFF, 4'hF, 8'hFF, 3'd0, 2'd0));
        tx.push_back(mk(8'h69, 4'h7, 8'h69, 3'd0, 2'd0));
        tx.push_back(mk(8'h96, 4'h8, 8'h96, 3'd0, 2'd0));
        repeat (5) cyc();
        chk("stall_accept", acc, 32'd2);
        out_ready = 1'b1;
        drain("drain_stall");
        chk("cnt_ok_stall", {16'd0, cnt_ok}, 32'd6);

        // Saturating 2-bit counters and clr coincident with a handshake.
        b_in_valid = 1'b1; b_in_cw = 8'h49;
        repeat (5) cyc();
        b_in_valid = 1'b0;
        repeat (4) cyc();
        chk("b_accepted", b_acc, 32'd5);
        chk("b_cnt_cor_sat", {30'd0, b_cnt_cor}, 32'd3);
        b_in_valid = 1'b1; b_in_cw = 8'h00;
        cyc();
        b_in_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (b_out_valid) begin
                found = 1'b1;
                b_clr = 1'b1;
            end
            cyc();
            b_clr = 1'b0;
        end
        chk("b_out_seen", {31'd0, found}, 32'd1);
        chk("b_clr_cnt_ok", {30'd0, b_cnt_ok}, 32'd0);
        chk("b_clr_cnt_cor", {30'd0, b_cnt_cor}, 32'd0);

        // Asynchronous reset with both stages full and the FSM halted.
        out_ready = 1'b0;
        tx.push_back(mk(8'h41, 4'h4, 8'h41, 3'd6, 2'd2));
        tx.push_back(mk(8'h00, 4'h0, 8'h00, 3'd0, 2'd0));
        repeat (4) cyc();
        chk("pre_rst_halted", {31'd0, halted}, 32'd1);
        chk("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
        chk("pre_rst_s1_full", {31'd0, in_ready}, 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_halted", {31'd0, halted}, 32'd0);
        chk("arst_out_word", {18'd0, out_data, out_cw, out_syn, out_status}, 32'd0);
        chk("arst_counters", {16'd0, cnt_ok | cnt_cor | cnt_ded}, 32'd0);
        tx.delete();
        sb.delete();
        stall_prev = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        repeat (5) cyc();
        chk("post_rst_sticky", {31'd0, sticky_ded}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
